// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request/response handshake and word-only data-port bundle
//                between the execute stage, the load/store unit and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    // Execute-stage request
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    // Response back to execute stage
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    // Word-only memory data port
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_we;
    logic [WIDTH-1:0] d_rdata;

    // The load/store unit itself
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  d_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output d_addr, d_wdata, d_we
    );

    // Execute stage plus memory, seen from the outside of the unit
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output d_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  d_addr, d_wdata, d_we
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : One-at-a-time byte/half/word load/store engine in front of a
//                word-only memory port. Sub-word stores use read-modify-write,
//                loads are sign- or zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ST_RD = 3'd2,
        S_ST_WR = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] c_byte_mask = WIDTH'(8'hFF);
    localparam logic [WIDTH-1:0] c_half_mask = WIDTH'(16'hFFFF);

    state_t           state_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_rdata_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] d_addr_q;
    logic [WIDTH-1:0] d_wdata_q;
    logic             w_bad;

    // Shift the addressed lane down to bit 0 and extend it to a full word.
    function automatic logic [WIDTH-1:0] f_extend(input logic [WIDTH-1:0] word,
                                                  input logic [1:0]       lane,
                                                  input logic [1:0]       size,
                                                  input logic             uns);
        logic [WIDTH-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return uns ? {{(WIDTH-8){1'b0}},  sh[7:0]}
                                : {{(WIDTH-8){sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {{(WIDTH-16){1'b0}},   sh[15:0]}
                                : {{(WIDTH-16){sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Replace the addressed lane of the old word with the right-aligned store data.
    // Half stores are aligned here, so lane is 0 or 2 and the shift is 0 or 16.
    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_word,
                                                 input logic [WIDTH-1:0] wd,
                                                 input logic [1:0]       lane,
                                                 input logic [1:0]       size);
        logic [WIDTH-1:0] mask;
        logic [4:0]       sh;
        sh = {lane, 3'b000};
        case (size)
            2'b00:   mask = c_byte_mask << sh;
            2'b01:   mask = c_half_mask << sh;
            default: mask = '1;
        endcase
        return (old_word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Illegal size or an address not aligned to the access size.
    always_comb begin
        w_bad = 1'b0;
        case (bus.req_size)
            2'b01:   w_bad = bus.req_addr[0];
            2'b10:   w_bad = (bus.req_addr[1:0] != 2'b00);
            2'b11:   w_bad = 1'b1;
            default: w_bad = 1'b0;
        endcase
    end

    // Request sequencing, memory port drive and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        size_q   <= bus.req_size;
                        uns_q    <= bus.req_unsigned;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        res_q    <= '0;
                        err_q    <= w_bad;
                        d_addr_q <= {bus.req_addr[WIDTH-1:2], 2'b00};
                        if (w_bad)
                            state_q <= S_RESP;
                        else if (bus.req_we)
                            state_q <= S_ST_RD;
                        else
                            state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    res_q   <= f_extend(bus.d_rdata, addr_q[1:0], size_q, uns_q);
                    state_q <= S_RESP;
                end
                S_ST_RD: begin
                    d_wdata_q <= f_merge(bus.d_rdata, wdata_q, addr_q[1:0], size_q);
                    state_q   <= S_ST_WR;
                end
                S_ST_WR: begin
                    d_wdata_q <= '0;
                    state_q   <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= res_q;
                    rsp_err_q   <= err_q;
                    d_addr_q    <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // we_q is kept for visibility of the in-flight request; state encodes it.
    logic w_unused;
    assign w_unused = we_q;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.d_addr    = d_addr_q;
    assign bus.d_wdata   = d_wdata_q;
    // Reset in the write cycle must suppress the memory write immediately.
    assign bus.d_we      = (state_q == S_ST_WR) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                small word-addressed backing memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   we_count = 0;
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Backing store: combinational read, write on posedge when d_we.
    assign bus.d_rdata = mem[bus.d_addr[5:2]];
    always @(posedge clk) begin
        if (bus.d_we) begin
            mem[bus.d_addr[5:2]] <= bus.d_wdata;
            we_count <= we_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for the response strobe, report latency.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle addr=%h: got %b want 1", addr, bus.req_ready);
        end
        tick;
        bus.req_valid = 1'b0;
        lat = 0; rdata = '0; err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (bus.rsp_valid === 1'b1) begin
                lat = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
                break;
            end
        end
        tick;
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_one_cycle addr=%h: got %b want 0", addr, bus.rsp_valid);
        end
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
            bus.rsp_err !== 1'b0 || bus.d_addr !== 32'h0 || bus.d_wdata !== 32'h0 || bus.d_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b rd=%h e=%b da=%h dw=%h we=%b want 1 0 0 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.d_addr, bus.d_wdata, bus.d_we);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEBABE, rd, e, lat);
        vectors++;
        if (lat != 3 || e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_0x4: got lat=%0d err=%b rd=%h want 3 0 00000000", lat, e, rd);
        end
        vectors++;
        if (mem[1] !== 32'hCAFEBABE) begin
            errors++; $display("FAIL sw_0x4_mem: got %h want cafebabe", mem[1]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, e, lat);
        vectors++;
        if (lat != 2 || e !== 1'b0 || rd !== 32'hCAFEBABE) begin
            errors++; $display("FAIL lw_0x4: got lat=%0d err=%b rd=%h want 2 0 cafebabe", lat, e, rd);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, rd, e, lat);
        do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA, rd, e, lat);
        vectors++;
        if (lat != 3 || e !== 1'b0 || mem[2] !== 32'h1234AA78) begin
            errors++; $display("FAIL sb_0x9: got lat=%0d err=%b mem=%h want 3 0 1234aa78", lat, e, mem[2]);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, rd, e, lat);
        vectors++;
        if (lat != 2 || rd !== 32'hFFFFFFAA) begin
            errors++; $display("FAIL lb_0x9: got lat=%0d rd=%h want 2 ffffffaa", lat, rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, e, lat);
        vectors++;
        if (lat != 2 || rd !== 32'h000000AA) begin
            errors++; $display("FAIL lbu_0x9: got lat=%0d rd=%h want 2 000000aa", lat, rd);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h00008001, rd, e, lat);
        vectors++;
        if (lat != 3 || e !== 1'b0 || mem[2] !== 32'h8001AA78) begin
            errors++; $display("FAIL sh_0xA: got lat=%0d err=%b mem=%h want 3 0 8001aa78", lat, e, mem[2]);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'hFFFF8001) begin
            errors++; $display("FAIL lh_0xA: got %h want ffff8001", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'h00008001) begin
            errors++; $display("FAIL lhu_0xA: got %h want 00008001", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'hFFFFAA78) begin
            errors++; $display("FAIL lh_0x8: got %h want ffffaa78", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e; int lat; int we0;
        logic        c_we   [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  c_size [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] c_addr [3] = '{32'h6, 32'h5, 32'h4};
        we0 = we_count;
        for (int i = 0; i < 3; i++) begin
            do_req(c_we[i], c_size[i], 1'b0, c_addr[i], 32'h0000DEAD, rd, e, lat);
            vectors++;
            if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL err_case%0d: got lat=%0d err=%b rd=%h want 1 1 00000000", i, lat, e, rd);
            end
        end
        vectors++;
        if (we_count != we0 || mem[1] !== 32'hCAFEBABE) begin
            errors++; $display("FAIL err_no_write: got writes=%0d mem=%h want 0 cafebabe", we_count - we0, mem[1]);
        end
    endtask

    task automatic test_reset_in_write;
        logic [31:0] rd; logic e; int lat; int pulses;
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h11; bus.req_valid = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        tick;
        vectors++;
        if (bus.d_we !== 1'b1 || bus.d_wdata !== 32'hCAFEBA11 || bus.d_addr !== 32'h4) begin
            errors++; $display("FAIL st_wr_drive: got we=%b wd=%h da=%h want 1 cafeba11 00000004", bus.d_we, bus.d_wdata, bus.d_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.d_we !== 1'b0) begin
            errors++; $display("FAIL rst_gates_we: got %b want 0", bus.d_we);
        end
        tick;
        rst = 1'b0;
        #1;
        vectors++;
        if (mem[1] !== 32'hCAFEBABE || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_wr: got mem=%h rdy=%b want cafebabe 1", mem[1], bus.req_ready);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid === 1'b1) pulses++;
            tick;
        end
        vectors++;
        if (pulses != 0) begin
            errors++; $display("FAIL rst_drops_rsp: got %0d pulses want 0", pulses);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'hCAFEBABE) begin
            errors++; $display("FAIL lw_after_rst: got %h want cafebabe", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic e; int lat; int we0; int pulses;
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h0, rd, e, lat);
        we0 = we_count;
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h8; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
        tick;
        // Second request held while the first is in flight.
        bus.req_we = 1'b1; bus.req_addr = 32'hC; bus.req_wdata = 32'h55AA55AA;
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL busy_not_ready: got %b want 0", bus.req_ready);
        end
        tick;
        tick;
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h8001AA78 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got v=%b rd=%h rdy=%b want 1 8001aa78 1", bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
        end
        bus.req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.rsp_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || we_count != we0 || mem[3] !== 32'h0) begin
            errors++; $display("FAIL b2b_ignored: got pulses=%0d writes=%0d mem=%h want 0 0 00000000", pulses, we_count - we0, mem[3]);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h55AA55AA, rd, e, lat);
        vectors++;
        if (lat != 3 || mem[3] !== 32'h55AA55AA) begin
            errors++; $display("FAIL b2b_second: got lat=%0d mem=%h want 3 55aa55aa", lat, mem[3]);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_reset_in_write;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
